// File: rtl/usb_pkg.sv
// Shared constants and types for the USB receive packet decoder.
package usb_pkg;

  // PID codes (low nibble of the PID byte)
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_DATA2 = 4'b0111;
  localparam logic [3:0] PID_MDATA = 4'b1111;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_NYET  = 4'b0110;

  typedef enum logic [2:0] {
    ClsToken,
    ClsSof,
    ClsData,
    ClsHsk,
    ClsOther
  } pid_class_e;

  // CRC parameters: non-reflected shift register fed LSB first
  localparam logic [4:0]  CRC5_POLY      = 5'h05;
  localparam logic [4:0]  CRC5_INIT      = 5'h1F;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  // err_code values
  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_PID_CHK   = 3'd1;
  localparam logic [2:0] ERR_CRC5      = 3'd2;
  localparam logic [2:0] ERR_LEN       = 3'd3;
  localparam logic [2:0] ERR_RX        = 3'd4;
  localparam logic [2:0] ERR_OVERFLOW  = 3'd5;
  localparam logic [2:0] ERR_PID_UNSUP = 3'd6;

  typedef enum logic [2:0] {
    StIdle,
    StPid,
    StToken,
    StData,
    StHsk,
    StDiscard
  } state_e;

  function automatic pid_class_e pid_class(input logic [3:0] pid);
    case (pid)
      PID_OUT, PID_IN, PID_SETUP:                 return ClsToken;
      PID_SOF:                                    return ClsSof;
      PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA: return ClsData;
      PID_ACK, PID_NAK, PID_STALL, PID_NYET:      return ClsHsk;
      default:                                    return ClsOther;
    endcase
  endfunction

endpackage

// File: rtl/usb_crc_byte.sv
// Byte-wide CRC update, data bits consumed LSB first, with clear and enable.
module usb_crc_byte #(
  parameter int unsigned   W    = 5,
  parameter logic [W-1:0]  POLY = W'(5),
  parameter logic [W-1:0]  INIT = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [7:0]   data,
  output logic [W-1:0] crc
);

  logic [W-1:0] crc_next;

  // Eight serial CRC steps unrolled into one cycle
  always_comb begin
    crc_next = crc;
    for (int i = 0; i < 8; i++) begin
      crc_next = {crc_next[W-2:0], 1'b0} ^ ((crc_next[W-1] ^ data[i]) ? POLY : '0);
    end
  end

  // CRC register; clear wins over enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= INIT;
    end else if (clr) begin
      crc <= INIT;
    end else if (en) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/usb_rx_pkt_decoder.sv
// USB packet-layer decoder: PID check, token/SOF decode with CRC5, data payload
// with CRC16 and 2-byte holdback, handshakes, and error reporting.
module usb_rx_pkt_decoder
  import usb_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 1023,
  parameter int unsigned CNT_W       = 11
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_active,
  input  logic        rx_error,
  output logic [3:0]  pid_o,
  output logic        tok_valid,
  output logic [6:0]  tok_addr,
  output logic [3:0]  tok_endp,
  output logic        sof_valid,
  output logic [10:0] frame_num,
  output logic [7:0]  data_o,
  output logic        data_valid,
  output logic        data_done,
  output logic        data_crc_ok,
  output logic        hs_valid,
  output logic        pkt_err,
  output logic [2:0]  err_code
);

  // Bytes after the PID: payload plus two CRC bytes
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MAX_PAYLOAD + 2);
  localparam logic [CNT_W-1:0] CntTwo  = CNT_W'(2);

  state_e           state_q;
  state_e           st_eff;
  logic             active_q;
  logic             rise, fall, acc, err_hit, take;
  logic [CNT_W-1:0] cnt_q;
  logic             is_sof_q;
  logic [7:0]       b0_q, b1_q;
  logic [7:0]       hold0_q, hold1_q;
  logic [2:0]       err_pend_q;
  logic             crc_clr, crc5_en, crc16_en;
  logic [4:0]       crc5;
  logic [15:0]      crc16;
  logic [10:0]      tok_field;

  assign tok_field = {b1_q[2:0], b0_q};

  // Edge detection, byte qualification and CRC control
  always_comb begin
    rise     = rx_active & ~active_q;
    fall     = ~rx_active & active_q;
    acc      = rx_valid & rx_active;
    // A rising rx_active always restarts at the PID, even after a missed end
    st_eff   = rise ? StPid : state_q;
    err_hit  = rx_active & rx_error & (st_eff != StIdle);
    take     = acc & ~err_hit;
    crc_clr  = take & (st_eff == StPid);
    crc5_en  = take & (st_eff == StToken) & (cnt_q < CntTwo);
    crc16_en = take & (st_eff == StData) & (cnt_q < CntLast);
  end

  usb_crc_byte #(
    .W    (5),
    .POLY (CRC5_POLY),
    .INIT (CRC5_INIT)
  ) u_crc5 (
    .clk  (CLK),
    .rst  (RST),
    .clr  (crc_clr),
    .en   (crc5_en),
    .data (rx_data),
    .crc  (crc5)
  );

  usb_crc_byte #(
    .W    (16),
    .POLY (CRC16_POLY),
    .INIT (CRC16_INIT)
  ) u_crc16 (
    .clk  (CLK),
    .rst  (RST),
    .clr  (crc_clr),
    .en   (crc16_en),
    .data (rx_data),
    .crc  (crc16)
  );

  // Packet FSM with registered event pulses and held fields
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      active_q    <= 1'b0;
      cnt_q       <= '0;
      is_sof_q    <= 1'b0;
      b0_q        <= '0;
      b1_q        <= '0;
      hold0_q     <= '0;
      hold1_q     <= '0;
      err_pend_q  <= ERR_NONE;
      pid_o       <= '0;
      tok_valid   <= 1'b0;
      tok_addr    <= '0;
      tok_endp    <= '0;
      sof_valid   <= 1'b0;
      frame_num   <= '0;
      data_o      <= '0;
      data_valid  <= 1'b0;
      data_done   <= 1'b0;
      data_crc_ok <= 1'b0;
      hs_valid    <= 1'b0;
      pkt_err     <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      tok_valid  <= 1'b0;
      sof_valid  <= 1'b0;
      data_valid <= 1'b0;
      data_done  <= 1'b0;
      hs_valid   <= 1'b0;
      pkt_err    <= 1'b0;
      active_q   <= rx_active;

      if (fall) begin
        state_q <= StIdle;
        case (state_q)
          StPid: begin
            pkt_err  <= 1'b1;
            err_code <= ERR_LEN;
          end
          StToken: begin
            if (cnt_q != CntTwo) begin
              pkt_err  <= 1'b1;
              err_code <= ERR_LEN;
            end else if (crc5 != CRC5_RESIDUAL) begin
              pkt_err  <= 1'b1;
              err_code <= ERR_CRC5;
            end else if (is_sof_q) begin
              sof_valid <= 1'b1;
              frame_num <= tok_field;
            end else begin
              tok_valid <= 1'b1;
              tok_addr  <= tok_field[6:0];
              tok_endp  <= tok_field[10:7];
            end
          end
          StData: begin
            if (cnt_q < CntTwo) begin
              pkt_err  <= 1'b1;
              err_code <= ERR_LEN;
            end else begin
              // CRC failure is reported here, not as a packet error
              data_done   <= 1'b1;
              data_crc_ok <= (crc16 == CRC16_RESIDUAL);
            end
          end
          StHsk: begin
            hs_valid <= 1'b1;
          end
          StDiscard: begin
            pkt_err  <= 1'b1;
            err_code <= err_pend_q;
          end
          default: ;
        endcase
      end else if (err_hit) begin
        state_q <= StDiscard;
        // Keep the first error seen in a packet
        if (st_eff != StDiscard) err_pend_q <= ERR_RX;
      end else if (take) begin
        case (st_eff)
          StPid: begin
            pid_o <= rx_data[3:0];
            cnt_q <= '0;
            if (rx_data[7:4] != ~rx_data[3:0]) begin
              state_q    <= StDiscard;
              err_pend_q <= ERR_PID_CHK;
            end else begin
              case (pid_class(rx_data[3:0]))
                ClsToken: begin
                  state_q  <= StToken;
                  is_sof_q <= 1'b0;
                end
                ClsSof: begin
                  state_q  <= StToken;
                  is_sof_q <= 1'b1;
                end
                ClsData:  state_q <= StData;
                ClsHsk:   state_q <= StHsk;
                default: begin
                  state_q    <= StDiscard;
                  err_pend_q <= ERR_PID_UNSUP;
                end
              endcase
            end
          end
          StToken: begin
            if (cnt_q == CntTwo) begin
              state_q    <= StDiscard;
              err_pend_q <= ERR_LEN;
            end else begin
              if (cnt_q == '0) b0_q <= rx_data;
              else             b1_q <= rx_data;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          StHsk: begin
            state_q    <= StDiscard;
            err_pend_q <= ERR_LEN;
          end
          StData: begin
            if (cnt_q == CntLast) begin
              state_q    <= StDiscard;
              err_pend_q <= ERR_OVERFLOW;
            end else begin
              // Two-byte holdback so the trailing CRC bytes are never forwarded
              hold0_q <= rx_data;
              hold1_q <= hold0_q;
              if (cnt_q >= CntTwo) begin
                data_o     <= hold1_q;
                data_valid <= 1'b1;
              end
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end else if (rise) begin
        state_q <= StPid;
      end
    end
  end

endmodule
